mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Responder side of the memctl request interface driven by the MEM pipeline stage.
- Converts one byte/half/word load or store request into a sequence of single-byte accesses on the external byte-wide synchronous RAM.
- Returns the loaded data with a one-cycle `memctl_fin` pulse.
- Sits between the MEM stage and the RAM port at the CPU top level.

Parameters:
ADDR_WIDTH, 32, width of mem_a; byte address is truncated to its low ADDR_WIDTH bits.

Ports:
clk_in  input  1  system clock, rising edge
rst_in  input  1  asynchronous, active-high reset
rdy_in  input  1  global ready; low = controller frozen
memctl_op  input  2  request op: 2'b00 NOP, 2'b01 LOAD, 2'b10 SAVE, 2'b11 treated as NOP
memctl_len  input  2  request size: 2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 treated as word
memctl_addr  input  32  byte address of first (least significant) byte
memctl_data  input  32  store data, little-endian, low bytes used
memctl_fin  output  1  one-cycle completion pulse
memctl_out  output  32  load result, zero-filled above len; valid while memctl_fin=1
mem_din  input  8  RAM read data
mem_dout  output  8  RAM write data
mem_a  output  ADDR_WIDTH  RAM byte address
mem_wr  output  1  RAM write enable

Behaviour:
- Reset (async, immediate): state IDLE, byte counter 0, memctl_fin=0, memctl_out=0, mem_a=0, mem_dout=0, internal write-enable=0. mem_wr drops to 0 in the same instant; a partially written word stays partial.
- RAM model:
  - RAM captures mem_a (and mem_dout when mem_wr=1) on a rising edge.
  - mem_din for that address is valid after that edge and holds while mem_a is unchanged.
- mem_wr = internal write-enable AND rdy_in (combinational gate). All other outputs are registered.
- rdy_in=0: every register holds. No state, counter or output changes. mem_wr=0.
- Request contract: MEM holds op/len/addr/data stable until it sees memctl_fin=1.
- N = 1/2/4 bytes for byte/half/word.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - op=NOP: stay.
  - op=LOAD: latch addr/len. mem_a<=addr, cnt<=0, memctl_out<=0. Go READ.
  - op=SAVE: latch addr/len/data. mem_a<=addr, mem_dout<=data[7:0], write-enable<=1, cnt<=0. Go WRITE.
- READ (two edges per byte):
  - Phase 0 edge: RAM captures mem_a.
  - Phase 1 edge: memctl_out[8*cnt+7:8*cnt]<=mem_din.
  - If cnt=N-1: memctl_fin<=1, go DONE. Else cnt<=cnt+1, mem_a<=mem_a+1, back to phase 0.
- WRITE (one edge per byte):
  - If cnt=N-1: write-enable<=0, memctl_fin<=1, go DONE.
  - Else cnt<=cnt+1, mem_a<=mem_a+1, mem_dout<=next data byte.
- DONE: memctl_fin=1 for exactly this cycle. Next edge: memctl_fin<=0, go IDLE. memctl_out holds until the next LOAD starts.
- The request present during DONE is never re-accepted. The first cycle in IDLE samples the next request, so there is a mandatory one-cycle bubble between back-to-back requests.
- Latency, counted from the first cycle a request is visible in IDLE with rdy_in=1, to the memctl_fin cycle, with no pauses:
  - LOAD: 2N cycles (LB 2, LH 4, LW 8).
  - SAVE: N cycles (SB 1, SH 2, SW 4).
- A pause extends latency by exactly its length in cycles.
- Byte order: little-endian. Byte k goes to / comes from address addr+k.
- Address increment wraps modulo 2^ADDR_WIDTH, so FFFFFFFF+1 = 0.
- No alignment requirement.
- Loads return zero-filled upper bytes; sign extension is the MEM stage's job.
- Op changing mid-transaction is a protocol violation and is ignored. The latched request completes.

Test Plan:
- LW addr 0x100, RAM[0x100..0x103]=11,22,33,44 -> mem_a steps 100→103; memctl_fin high only in cycle 8; memctl_out=0x44332211; mem_wr never 1.
- SW addr 0x200, data 0xDEADBEEF -> mem_wr=1 in cycles 0-3 with mem_a 200..203 and mem_dout EF,BE,AD,DE; fin in cycle 4; RAM[0x200..0x203] updated; RAM[0x204] unchanged.
- LB addr 0x3 (RAM=0x80) followed immediately by SH addr 0x10 data 0x1234 -> out=0x00000080, fin cycle 2. DONE bubble, then SH accepted. Writes 34@0x10, 12@0x11; fin 2 cycles after acceptance.
- LW addr 0x100 with rdy_in=0 for 3 cycles starting at cycle 3 -> all outputs frozen during the pause; fin in cycle 11; memctl_out=0x44332211.
- SW addr 0x300 with rst_in pulsed asynchronously mid-cycle 2 -> mem_wr falls immediately; only 0x300/0x301 written; fin stays 0; controller IDLE after release.
- SH addr 0xFFFFFFFF, data 0xABCD -> CD written to 0xFFFFFFFF, AB to 0x0 (wrap); op=2'b11 and memctl_len=2'b11 cases checked as NOP and word respectively.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises byte/half/word load and store requests from the MEM
// stage into single-byte accesses on a byte-wide synchronous RAM.
module mem_ctrl #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic [1:0]            memctl_op,
   input  logic [1:0]            memctl_len,
   input  logic [31:0]           memctl_addr,
   input  logic [31:0]           memctl_data,
   output logic                  memctl_fin,
   output logic [31:0]           memctl_out,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr
);

   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_SAVE  = 2'b10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]            state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  phase_q, phase_d;
   logic [1:0]            last_q, last_d;
   logic [31:0]           data_q, data_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            dout_q, dout_d;
   logic                  we_q, we_d;
   logic                  fin_q, fin_d;
   logic [31:0]           out_q, out_d;
   logic [1:0]            nxt_cnt;

   // Index of the final byte: len 2'b11 is handled as a word.
   function automatic logic [1:0] last_byte(input logic [1:0] len);
      case (len)
         2'b00:   last_byte = 2'd0;
         2'b01:   last_byte = 2'd1;
         default: last_byte = 2'd3;
      endcase
   endfunction

   assign nxt_cnt = cnt_q + 2'd1;

   always_comb begin
      // NOTE: every next-state signal defaults to its register so that no path
      // through the case statement can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      last_d  = last_q;
      data_d  = data_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      we_d    = we_q;
      fin_d   = fin_q;
      out_d   = out_q;

      if (rdy_in) begin
         case (state_q)
            ST_IDLE: begin
               if (memctl_op == OP_LOAD) begin
                  addr_d  = memctl_addr[ADDR_WIDTH-1:0];
                  last_d  = last_byte(memctl_len);
                  cnt_d   = 2'd0;
                  phase_d = 1'b0;
                  out_d   = 32'h0;
                  state_d = ST_READ;
               end else if (memctl_op == OP_SAVE) begin
                  addr_d  = memctl_addr[ADDR_WIDTH-1:0];
                  last_d  = last_byte(memctl_len);
                  data_d  = memctl_data;
                  dout_d  = memctl_data[7:0];
                  we_d    = 1'b1;
                  cnt_d   = 2'd0;
                  state_d = ST_WRITE;
               end
            end

            // Phase 0 lets the RAM register mem_a; phase 1 consumes mem_din.
            ST_READ: begin
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  out_d[{cnt_q, 3'b000} +: 8] = mem_din;
                  if (cnt_q == last_q) begin
                     fin_d   = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     cnt_d  = nxt_cnt;
                     addr_d = addr_q + ADDR_ONE;
                  end
               end
            end

            ST_WRITE: begin
               if (cnt_q == last_q) begin
                  we_d    = 1'b0;
                  fin_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  cnt_d  = nxt_cnt;
                  addr_d = addr_q + ADDR_ONE;
                  dout_d = data_q[{nxt_cnt, 3'b000} +: 8];
               end
            end

            // The request still on the bus here is the one just finished.
            ST_DONE: begin
               fin_d   = 1'b0;
               state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
         phase_q <= 1'b0;
         last_q  <= 2'd0;
         data_q  <= 32'h0;
         addr_q  <= '0;
         dout_q  <= 8'h0;
         we_q    <= 1'b0;
         fin_q   <= 1'b0;
         out_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         last_q  <= last_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         we_q    <= we_d;
         fin_q   <= fin_d;
         out_q   <= out_d;
      end
   end

   assign memctl_fin = fin_q;
   assign memctl_out = out_q;
   assign mem_a      = addr_q;
   assign mem_dout   = dout_q;
   // A frozen controller must never write, even mid-store.
   assign mem_wr     = we_q & rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a table of chained requests checked through a scoreboard
// of load results and a write log, plus pause and mid-store reset sequences.
`timescale 1ns/1ps
module tb_mem_ctrl;

   localparam logic [1:0] NOP  = 2'b00;
   localparam logic [1:0] LOAD = 2'b01;
   localparam logic [1:0] SAVE = 2'b10;
   localparam int NV = 10;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic [1:0]  memctl_op;
   logic [1:0]  memctl_len;
   logic [31:0] memctl_addr;
   logic [31:0] memctl_data;
   logic        memctl_fin;
   logic [31:0] memctl_out;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;

   mem_ctrl #(.ADDR_WIDTH(32)) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .rdy_in      (rdy_in),
      .memctl_op   (memctl_op),
      .memctl_len  (memctl_len),
      .memctl_addr (memctl_addr),
      .memctl_data (memctl_data),
      .memctl_fin  (memctl_fin),
      .memctl_out  (memctl_out),
      .mem_din     (mem_din),
      .mem_dout    (mem_dout),
      .mem_a       (mem_a),
      .mem_wr      (mem_wr)
   );

   always #5 clk_in = ~clk_in;

   // Byte RAM keyed on the low 12 address bits; unwritten bytes read preset contents.
   logic [7:0] ram [0:4095];
   bit         written [0:4095];

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      case (a)
         32'h0000_0003: init_byte = 8'h80;
         32'h0000_0100: init_byte = 8'h11;
         32'h0000_0101: init_byte = 8'h22;
         32'h0000_0102: init_byte = 8'h33;
         32'h0000_0103: init_byte = 8'h44;
         32'h0000_0104: init_byte = 8'h9A;
         32'h0000_0204: init_byte = 8'h77;
         32'h0000_0302: init_byte = 8'h55;
         32'h0000_0303: init_byte = 8'h66;
         default:       init_byte = 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] rd(input logic [31:0] a);
      rd = written[a[11:0]] ? ram[a[11:0]] : init_byte(a);
   endfunction

   always @(posedge clk_in) begin
      if (mem_wr) begin
         ram[mem_a[11:0]]     <= mem_dout;
         written[mem_a[11:0]] <= 1'b1;
      end
      mem_din <= rd(mem_a);
   end

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  len;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_out;
      int          exp_lat;
      int          exp_wr;
   } vec_t;

   vec_t        vecs [NV];
   logic [31:0] sb [$];
   logic [39:0] wlog [$];
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Write log and load-result scoreboard, sampled mid-cycle.
   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (mem_wr) wlog.push_back({mem_a, mem_dout});
         if (memctl_fin) begin
            if (sb.size() == 0) check("unexpected_fin", {63'h0, memctl_fin}, 64'h0);
            else check("fin_out", {32'h0, memctl_out}, {32'h0, sb.pop_front()});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          wbase;
      int          n_wr;
      int          fin_j;
      logic        busy_seen;
      logic [31:0] ea;
      logic [7:0]  ed;
      vec_t        v;

      //          op    len    addr          data          exp_out       lat wr
      vecs[0] = '{LOAD, 2'b10, 32'h0000_0100, 32'h0,        32'h4433_2211, 8, 0};
      vecs[1] = '{SAVE, 2'b10, 32'h0000_0200, 32'hDEAD_BEEF, 32'h4433_2211, 4, 4};
      vecs[2] = '{LOAD, 2'b00, 32'h0000_0003, 32'h0,        32'h0000_0080, 2, 0};
      vecs[3] = '{SAVE, 2'b01, 32'h0000_0010, 32'h5A5A_1234, 32'h0000_0080, 2, 2};
      vecs[4] = '{LOAD, 2'b01, 32'h0000_0200, 32'h0,        32'h0000_BEEF, 4, 0};
      vecs[5] = '{SAVE, 2'b01, 32'hFFFF_FFFF, 32'h0000_ABCD, 32'h0000_BEEF, 2, 2};
      vecs[6] = '{LOAD, 2'b01, 32'hFFFF_FFFF, 32'h0,        32'h0000_ABCD, 4, 0};
      vecs[7] = '{SAVE, 2'b11, 32'h0000_0400, 32'h0102_0304, 32'h0000_ABCD, 4, 4};
      vecs[8] = '{LOAD, 2'b11, 32'h0000_0400, 32'h0,        32'h0102_0304, 8, 0};
      vecs[9] = '{LOAD, 2'b10, 32'h0000_0101, 32'h0,        32'h9A44_3322, 8, 0};

      rst_in      = 1'b1;
      rdy_in      = 1'b1;
      memctl_op   = NOP;
      memctl_len  = 2'b00;
      memctl_addr = 32'h0;
      memctl_data = 32'h0;

      #12;
      check("rst_fin",  {63'h0, memctl_fin}, 64'h0);
      check("rst_out",  {32'h0, memctl_out}, 64'h0);
      check("rst_a",    {32'h0, mem_a},      64'h0);
      check("rst_dout", {56'h0, mem_dout},   64'h0);
      check("rst_wr",   {63'h0, mem_wr},     64'h0);
      @(negedge clk_in);
      rst_in = 1'b0;

      // op 2'b11 must be ignored like a NOP.
      memctl_op   = 2'b11;
      memctl_len  = 2'b10;
      memctl_addr = 32'h0000_0055;
      memctl_data = 32'hCAFE_F00D;
      wbase       = wlog.size();
      busy_seen   = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_in);
         busy_seen = busy_seen | memctl_fin | mem_wr;
      end
      check("op11_quiet", {63'h0, busy_seen}, 64'h0);
      check("op11_a",     {32'h0, mem_a},     64'h0);
      check("op11_wlog",  64'(wlog.size() - wbase), 64'h0);

      // Chained table: each next request is presented during the previous DONE cycle.
      for (int i = 0; i < NV; i++) begin
         v           = vecs[i];
         wbase       = wlog.size();
         memctl_op   = v.op;
         memctl_len  = v.len;
         memctl_addr = v.addr;
         memctl_data = v.data;
         sb.push_back(v.exp_out);
         fin_j = -1;
         for (int j = 1; j <= 40; j++) begin
            @(negedge clk_in);
            if (memctl_fin) begin
               fin_j = j;
               break;
            end
         end
         check($sformatf("v%0d_latency", i), 64'(fin_j), 64'(v.exp_lat + 1 + ((i > 0) ? 1 : 0)));
         n_wr = wlog.size() - wbase;
         check($sformatf("v%0d_wr_count", i), 64'(n_wr), 64'(v.exp_wr));
         for (int k = 0; k < v.exp_wr && k < n_wr; k++) begin
            ea = v.addr + 32'(k);
            ed = v.data[8*k +: 8];
            check($sformatf("v%0d_wr%0d", i, k), {24'h0, wlog[wbase + k]}, {24'h0, ea, ed});
         end
      end
      memctl_op = NOP;
      @(negedge clk_in);
      check("fin_pulse_end", {63'h0, memctl_fin}, 64'h0);

      check("ram_200", {56'h0, rd(32'h200)}, 64'hEF);
      check("ram_201", {56'h0, rd(32'h201)}, 64'hBE);
      check("ram_202", {56'h0, rd(32'h202)}, 64'hAD);
      check("ram_203", {56'h0, rd(32'h203)}, 64'hDE);
      check("ram_204", {56'h0, rd(32'h204)}, 64'h77);
      check("ram_010", {56'h0, rd(32'h010)}, 64'h34);
      check("ram_011", {56'h0, rd(32'h011)}, 64'h12);
      check("ram_fff", {56'h0, rd(32'hFFFF_FFFF)}, 64'hCD);
      check("ram_000", {56'h0, rd(32'h000)}, 64'hAB);

      // LW 0x100 with rdy_in low during cycles 3..5 after acceptance.
      wbase       = wlog.size();
      memctl_op   = LOAD;
      memctl_len  = 2'b10;
      memctl_addr = 32'h0000_0100;
      sb.push_back(32'h4433_2211);
      fin_j = -1;
      @(posedge clk_in);
      for (int c = 0; c < 40; c++) begin
         #1;
         if (c == 3) rdy_in = 1'b0;
         if (c == 6) rdy_in = 1'b1;
         @(negedge clk_in);
         if (c >= 3 && c <= 5) begin
            check($sformatf("pause%0d_a", c),   {32'h0, mem_a},      64'h101);
            check($sformatf("pause%0d_out", c), {32'h0, memctl_out}, 64'h11);
            check($sformatf("pause%0d_wr", c),  {63'h0, mem_wr},     64'h0);
         end
         if (memctl_fin) begin
            fin_j = c;
            break;
         end
         @(posedge clk_in);
      end
      check("pause_fin_cycle", 64'(fin_j), 64'd11);
      check("pause_wlog", 64'(wlog.size() - wbase), 64'h0);
      memctl_op = NOP;
      rdy_in    = 1'b1;
      @(negedge clk_in);

      // SW 0x300 interrupted by reset during its third write cycle.
      wbase       = wlog.size();
      memctl_op   = SAVE;
      memctl_len  = 2'b10;
      memctl_addr = 32'h0000_0300;
      memctl_data = 32'hA1B2_C3D4;
      repeat (3) @(posedge clk_in);
      #3;
      rst_in    = 1'b1;
      memctl_op = NOP;
      #1;
      check("arst_wr",  {63'h0, mem_wr},     64'h0);
      check("arst_fin", {63'h0, memctl_fin}, 64'h0);
      check("arst_a",   {32'h0, mem_a},      64'h0);
      check("arst_out", {32'h0, memctl_out}, 64'h0);
      @(negedge clk_in);
      rst_in    = 1'b0;
      busy_seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_in);
         busy_seen = busy_seen | memctl_fin | mem_wr;
      end
      check("arst_quiet", {63'h0, busy_seen}, 64'h0);
      check("arst_wlog",  64'(wlog.size() - wbase), 64'd2);
      check("ram_300", {56'h0, rd(32'h300)}, 64'hD4);
      check("ram_301", {56'h0, rd(32'h301)}, 64'hC3);
      check("ram_302", {56'h0, rd(32'h302)}, 64'h55);
      check("ram_303", {56'h0, rd(32'h303)}, 64'h66);

      // Controller must be back in IDLE: a fresh LB completes normally.
      memctl_op   = LOAD;
      memctl_len  = 2'b00;
      memctl_addr = 32'h0000_0003;
      sb.push_back(32'h0000_0080);
      fin_j = -1;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk_in);
         if (memctl_fin) begin
            fin_j = j;
            break;
         end
      end
      check("post_rst_lb_latency", 64'(fin_j), 64'd3);
      memctl_op = NOP;
      @(negedge clk_in);
      check("sb_empty", 64'(sb.size()), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
